// File: rtl/fsm_control_param.sv
// fsm_control_param
// Supervisory state machine for a bank of NUM_FIFOS FIFOs. Captures per-FIFO
// almost-full/almost-empty thresholds while in INIT, tracks bank activity with
// a debounced return to IDLE, and latches which FIFOs raised an error.
module fsm_control_param #(
  parameter int NUM_FIFOS   = 5,
  parameter int TH_W        = 4,
  parameter int TH_DEFAULT  = 1,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]      FIFO_error,
  input  logic [NUM_FIFOS-1:0]      FIFO_empty,
  output logic [NUM_FIFOS*TH_W-1:0] umbrales_out,
  output logic                      active,
  output logic                      idle,
  output logic                      error,
  output logic [NUM_FIFOS-1:0]      error_src,
  output logic [2:0]                state
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  // Counter only has to reach IDLE_CYCLES, so it never needs to wrap.
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES);
  localparam logic [TH_W-1:0]  TH_DEF   = TH_W'(TH_DEFAULT);

  logic [2:0]                state_q, state_d;
  logic [NUM_FIFOS*TH_W-1:0] umbrales_q, umbrales_d;
  logic [NUM_FIFOS-1:0]      error_src_q, error_src_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NUM_FIFOS*TH_W-1:0] umbral_subst;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      any_error;
  logic                      all_empty;

  assign any_error = |FIFO_error;
  assign all_empty = &FIFO_empty;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Zero-valued threshold fields are replaced with the default value.
  generate
    for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_subst
      assign umbral_subst[gi*TH_W +: TH_W] =
        (umbral_in[gi*TH_W +: TH_W] == '0) ? TH_DEF : umbral_in[gi*TH_W +: TH_W];
    end
  endgenerate

  // Next-state, threshold, error-source and debounce-counter logic.
  always_comb begin
    state_d     = state_q;
    umbrales_d  = umbrales_q;
    error_src_d = error_src_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_RESET: begin
        state_d = S_INIT;
      end

      S_INIT: begin
        umbrales_d = umbral_in;
        if (any_error) begin
          state_d     = S_ERROR;
          error_src_d = error_src_q | FIFO_error;
        end else if (!init) begin
          state_d    = S_IDLE;
          umbrales_d = umbral_subst;
        end
      end

      S_IDLE: begin
        if (any_error) begin
          state_d     = S_ERROR;
          error_src_d = error_src_q | FIFO_error;
        end else if (init) begin
          state_d = S_INIT;
        end else if (!all_empty) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end
      end

      S_ACTIVE: begin
        if (any_error) begin
          state_d     = S_ERROR;
          error_src_d = error_src_q | FIFO_error;
          cnt_d       = '0;
        end else if (init) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (all_empty) begin
          if (cnt_inc == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end

      S_ERROR: begin
        // Sticky: accumulate every error source seen until reset.
        error_src_d = error_src_q | FIFO_error;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RESET;
      umbrales_q  <= '0;
      error_src_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      umbrales_q  <= umbrales_d;
      error_src_q <= error_src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign umbrales_out = umbrales_q;
  assign error_src    = error_src_q;
  assign state        = state_q;
  assign active       = (state_q == S_ACTIVE);
  assign idle         = (state_q == S_IDLE);
  assign error        = (state_q == S_ERROR);

endmodule
